instruction_fetch_sequencer: RTL

//  Program-counter and fetch controller for the combinational 512x16 instruction ROM.

---
 rtl/processorc_fetch_pkg.sv | 18 +
 rtl/instruction_fetch_sequencer_if.sv | 42 ++++
 rtl/fetch_queue.sv | 87 ++++++++
 rtl/instruction_fetch_sequencer.sv | 67 ++++++
 4 files changed

// File: rtl/processorc_fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
// A fetch entry pairs an instruction with the PC it was read from.
package processorc_fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // True when no PC bit above the implemented ROM address range is set.
  function automatic logic pc_in_range(input logic [PC_W-1:0] pc, input int unsigned addr_w);
    return (pc >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/instruction_fetch_sequencer_if.sv
// ROM, redirect/halt control and decode handshake signals of the fetch sequencer.
// master is the sequencer side, slave the ROM/decode environment side.
interface instruction_fetch_sequencer_if;

  logic [15:0] RomAddress;
  logic [15:0] RomData;
  logic        RedirectValid;
  logic [15:0] RedirectTarget;
  logic        Halt;
  logic        DecodeValid;
  logic        DecodeReady;
  logic [15:0] DecodeInstruction;
  logic [15:0] DecodePC;
  logic        FetchFault;

  modport master (
    output RomAddress,
    input  RomData,
    input  RedirectValid,
    input  RedirectTarget,
    input  Halt,
    output DecodeValid,
    input  DecodeReady,
    output DecodeInstruction,
    output DecodePC,
    output FetchFault
  );

  modport slave (
    input  RomAddress,
    output RomData,
    output RedirectValid,
    output RedirectTarget,
    output Halt,
    input  DecodeValid,
    output DecodeReady,
    input  DecodeInstruction,
    input  DecodePC,
    input  FetchFault
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with a registered head and a priority flush.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fetch_queue
  import processorc_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W:0] ptr_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);

  fetch_entry_t r_mem [DEPTH];
  fetch_entry_t r_head;
  fetch_entry_t w_head_next;
  ptr_t         r_wr;
  ptr_t         r_rd;
  ptr_t         w_wr_next;
  ptr_t         w_rd_next;
  logic         w_do_push;
  logic         w_do_pop;
  logic         w_empty_next;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]) && (r_wr[PTR_W] != r_rd[PTR_W]);

  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  always_comb begin
    w_wr_next   = r_wr;
    w_rd_next   = r_rd;
    w_head_next = '0;
    if (i_flush) begin
      w_wr_next = '0;
      w_rd_next = '0;
    end else begin
      if (w_do_push) w_wr_next = r_wr + PTR_ONE;
      if (w_do_pop)  w_rd_next = r_rd + PTR_ONE;
    end
    w_empty_next = (w_wr_next == w_rd_next);
    // The slot being written this cycle is not in r_mem yet; bypass it into the head.
    if (!w_empty_next) begin
      if (w_do_push && (r_wr[PTR_W-1:0] == w_rd_next[PTR_W-1:0])) begin
        w_head_next = i_data;
      end else begin
        w_head_next = r_mem[w_rd_next[PTR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else begin
      r_wr   <= w_wr_next;
      r_rd   <= w_rd_next;
      r_head <= w_head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[PTR_W-1:0]] <= i_data;
  end

  assign o_head = r_head;

  no_push_when_full: assert property (
    @(posedge clk) disable iff (!sync_rst)
    !(i_push && o_full && !w_do_pop && !i_flush)
  );

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Program counter and fetch controller for a combinational instruction ROM; feeds decode
// through a prefetch queue and handles redirects, halt and out-of-range fetch faults.
module instruction_fetch_sequencer
  import processorc_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0001,
  parameter int unsigned     ROM_ADDR_W   = 9,
  parameter int unsigned     QUEUE_DEPTH  = 2
) (
  input logic                           clk,
  input logic                           sync_rst,
  instruction_fetch_sequencer_if.master bus
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [PC_W-1:0] r_pc;
  logic            r_fault;
  logic            w_in_range;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  fetch_entry_t    w_fetch;
  fetch_entry_t    w_head;

  assign w_in_range = pc_in_range(r_pc, ROM_ADDR_W);
  assign w_pop      = !w_empty && bus.DecodeReady;
  // A pop frees a slot in the same cycle, so a full queue still streams at one entry per cycle.
  assign w_push     = !bus.RedirectValid && !bus.Halt && !r_fault && w_in_range &&
                      (!w_full || w_pop);
  assign w_fetch    = '{pc: r_pc, instr: bus.RomData};

  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      r_pc    <= RESET_VECTOR;
      r_fault <= 1'b0;
    end else if (bus.RedirectValid) begin
      r_pc    <= bus.RedirectTarget;
      r_fault <= 1'b0;
    end else begin
      if (w_push) r_pc <= r_pc + PC_ONE;
      if (!bus.Halt && !w_in_range) r_fault <= 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk      (clk),
    .sync_rst (sync_rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (bus.RedirectValid),
    .i_data   (w_fetch),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign bus.RomAddress        = r_pc;
  assign bus.DecodeValid       = !w_empty;
  assign bus.DecodePC          = w_head.pc;
  assign bus.DecodeInstruction = w_head.instr;
  assign bus.FetchFault        = r_fault;

endmodule
